// File: rtl/aes_axis_packer.sv
// aes_axis_packer: AXI-Stream slave that latches a command word, then packs the
// remaining 32-bit beats into 128-bit blocks (first word in MSBs) for the input FIFO.
`default_nettype none

module aes_axis_packer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 128,
  parameter int WORDS_PER_BLK   = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] aes_cmd,
  output logic                       in_fifo_write_tvalid,
  input  logic                       in_fifo_write_tready,
  output logic [FIFO_DATA_WIDTH-1:0] in_fifo_data,
  output logic                       axis_slave_done,
  input  logic                       processing_done
);

  localparam int CNT_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {
    GET_CMD = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       tready_q, tready_d;
  logic                       tvalid_q, tvalid_d;
  logic                       done_q, done_d;
  logic                       last_seen_q, last_seen_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [AXIS_DATA_WIDTH-1:0] cmd_q, cmd_d;
  logic [FIFO_DATA_WIDTH-1:0] data_q, data_d;

  logic beat_taken;
  logic write_done;

  assign beat_taken = s_axis_tvalid && tready_q;
  assign write_done = tvalid_q && in_fifo_write_tready;

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    done_d      = done_q;
    last_seen_d = last_seen_q;
    beat_cnt_d  = beat_cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;

    unique case (state_q)
      GET_CMD: begin
        if (beat_taken) begin
          cmd_d = s_axis_tdata;
          if (s_axis_tlast) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = COLLECT;
            beat_cnt_d = '0;
            data_d     = '0;
          end
        end
      end
      COLLECT: begin
        if (beat_taken) begin
          for (int k = 0; k < WORDS_PER_BLK; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
              data_d[FIFO_DATA_WIDTH-1-AXIS_DATA_WIDTH*k -: AXIS_DATA_WIDTH] = s_axis_tdata;
            end
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if ((beat_cnt_q == LAST_IDX) || s_axis_tlast) begin
            tvalid_d    = 1'b1;
            last_seen_d = s_axis_tlast;
            state_d     = PUSH;
          end
        end
      end
      PUSH: begin
        if (write_done) begin
          tvalid_d   = 1'b0;
          beat_cnt_d = '0;
          data_d     = '0;
          if (last_seen_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      DONE: begin
        if (processing_done) begin
          done_d  = 1'b0;
          state_d = GET_CMD;
        end
      end
      default: state_d = GET_CMD;
    endcase

    // Ready is registered, so it follows the state being entered.
    tready_d = (state_d == GET_CMD) || (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= GET_CMD;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      last_seen_q <= 1'b0;
      beat_cnt_q  <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
      last_seen_q <= last_seen_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
    end
  end

  assign s_axis_tready        = tready_q;
  assign in_fifo_write_tvalid = tvalid_q;
  assign in_fifo_data         = data_q;
  assign aes_cmd              = cmd_q;
  assign axis_slave_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_axis_packer.sv
// Scoreboard bench for aes_axis_packer: directed packets, FIFO stall, done hold, mid-packet reset.
`default_nettype none

module tb_aes_axis_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [31:0]  aes_cmd;
  logic         in_fifo_write_tvalid;
  logic         in_fifo_write_tready;
  logic [127:0] in_fifo_data;
  logic         axis_slave_done;
  logic         processing_done;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  aes_axis_packer dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .aes_cmd              (aes_cmd),
    .in_fifo_write_tvalid (in_fifo_write_tvalid),
    .in_fifo_write_tready (in_fifo_write_tready),
    .in_fifo_data         (in_fifo_data),
    .axis_slave_done      (axis_slave_done),
    .processing_done      (processing_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Monitor: every accepted FIFO write is compared with the oldest expected block.
  always @(negedge clk) begin
    if (reset && in_fifo_write_tvalid && in_fifo_write_tready) begin
      if (sb.size() == 0) fail("unexpected_fifo_write");
      else chk("fifo_data", in_fifo_data, sb.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("beat_accept_timeout");
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!axis_slave_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("done_timeout");
    chk("writes_before_done", 128'(sb.size()), 128'd0);
  endtask

  task automatic rearm();
    processing_done = 1'b1;
    @(negedge clk);
    processing_done = 1'b0;
    chk("rearm_done", 128'(axis_slave_done), 128'd0);
    chk("rearm_tready", 128'(s_axis_tready), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset                = 1'b0;
    s_axis_tvalid        = 1'b1;
    s_axis_tdata         = 32'h1234_5678;
    s_axis_tlast         = 1'b0;
    in_fifo_write_tready = 1'b1;
    processing_done      = 1'b0;

    // Reset with tvalid asserted
    repeat (3) @(negedge clk);
    chk("rst_tready", 128'(s_axis_tready), 128'd0);
    chk("rst_tvalid", 128'(in_fifo_write_tvalid), 128'd0);
    chk("rst_done",   128'(axis_slave_done), 128'd0);
    chk("rst_cmd",    128'(aes_cmd), 128'd0);
    chk("rst_data",   in_fifo_data, 128'd0);
    s_axis_tvalid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 128'(s_axis_tready), 128'd1);

    // Command-only packet
    send_beat(32'h0000_0040, 1'b1);
    wait_done();
    chk("cmd_only", 128'(aes_cmd), 128'h40);
    rearm();

    // One full block with tlast on the 4th word
    sb.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    send_beat(32'h0000_0010, 1'b0);
    send_beat(32'h0011_2233, 1'b0);
    send_beat(32'h4455_6677, 1'b0);
    send_beat(32'h8899_AABB, 1'b0);
    send_beat(32'hCCDD_EEFF, 1'b1);
    wait_done();
    chk("cmd_pkt1", 128'(aes_cmd), 128'h10);
    rearm();

    // Nine data words: two full blocks and one short block
    sb.push_back(128'hA0000001_A0000002_A0000003_A0000004);
    sb.push_back(128'hA0000005_A0000006_A0000007_A0000008);
    sb.push_back(128'hA0000009_00000000_00000000_00000000);
    send_beat(32'h0000_0020, 1'b0);
    for (int i = 1; i <= 9; i++) send_beat(32'hA000_0000 + 32'(i), i == 9);
    wait_done();
    chk("cmd_pkt2", 128'(aes_cmd), 128'h20);
    rearm();

    // FIFO full for 20 cycles while a block is pending
    in_fifo_write_tready = 1'b0;
    sb.push_back(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);
    send_beat(32'h0000_0030, 1'b0);
    send_beat(32'hDEAD_BEEF, 1'b0);
    send_beat(32'hCAFE_BABE, 1'b0);
    send_beat(32'h0123_4567, 1'b0);
    send_beat(32'h89AB_CDEF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("stall_tvalid", 128'(in_fifo_write_tvalid), 128'd1);
      chk("stall_tready", 128'(s_axis_tready), 128'd0);
      chk("stall_data", in_fifo_data, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_fifo_write_tready = 1'b1;
    @(negedge clk);
    wait_done();
    chk("cmd_pkt3", 128'(aes_cmd), 128'h30);

    // Done held until processing_done
    for (int i = 0; i < 10; i++) begin
      chk("hold_tready", 128'(s_axis_tready), 128'd0);
      chk("hold_done", 128'(axis_slave_done), 128'd1);
      @(negedge clk);
    end
    rearm();

    // Reset mid-block after two data beats
    send_beat(32'h0000_00AA, 1'b0);
    send_beat(32'h1111_1111, 1'b0);
    send_beat(32'h2222_2222, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(in_fifo_write_tvalid), 128'd0);
    chk("midrst_tready", 128'(s_axis_tready), 128'd0);
    chk("midrst_cmd", 128'(aes_cmd), 128'd0);
    chk("midrst_data", in_fifo_data, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.push_back(128'h55550001_00000000_00000000_00000000);
    send_beat(32'h0000_0055, 1'b0);
    send_beat(32'h5555_0001, 1'b1);
    wait_done();
    chk("cmd_after_rst", 128'(aes_cmd), 128'h55);
    rearm();

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
